// File: rtl/vga_timing_generator_if.sv
// Pixel-position / RGB bus between the VGA timing generator and the video compositor.
// The timing generator drives raster position and framing; the compositor returns RGB.
interface vga_timing_generator_if;
    logic [9:0] pixel_x_pos;
    logic [9:0] pixel_y_pos;
    logic       active_area;
    logic       frame_start;
    logic [7:0] pixel_red;
    logic [7:0] pixel_green;
    logic [7:0] pixel_blue;

    modport master (
        output pixel_x_pos, pixel_y_pos, active_area, frame_start,
        input  pixel_red, pixel_green, pixel_blue
    );

    modport slave (
        input  pixel_x_pos, pixel_y_pos, active_area, frame_start,
        output pixel_red, pixel_green, pixel_blue
    );
endinterface

// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: position counters for the compositor, sync/blank delayed
// to line up with the compositor's RGB, and a registered RGB stage toward the DAC.
module vga_timing_generator #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pixel_enable,
    vga_timing_generator_if.master        pix,
    output logic                          vga_hsync,
    output logic                          vga_vsync,
    output logic                          vga_blank_n,
    output logic [7:0]                    vga_red,
    output logic [7:0]                    vga_green,
    output logic [7:0]                    vga_blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_totals
        $error("vga_timing_generator: H_TOTAL/V_TOTAL must fit in 10-bit counters");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_generator: PIPE_DELAY must be in 1..7");
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       frame_start_q;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       active_raw;

    // Each stage is {hsync, vsync, blank_n}; chain[2:0] is the undelayed decode.
    logic [3*PIPE_DELAY-1:0] sync_sr;
    logic [3*PIPE_DELAY+2:0] chain;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h_count       <= '0;
            v_count       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (pixel_enable) begin
                if (h_count == H_LAST) begin
                    h_count <= '0;
                    if (v_count == V_LAST) begin
                        v_count       <= '0;
                        frame_start_q <= 1'b1;
                    end else begin
                        v_count <= v_count + 10'd1;
                    end
                end else begin
                    h_count <= h_count + 10'd1;
                end
            end
        end
    end

    always_comb begin
        hsync_raw  = !((h_count >= HS_START) && (h_count < HS_END));
        vsync_raw  = !((v_count >= VS_START) && (v_count < VS_END));
        active_raw = (h_count < H_VIS) && (v_count < V_VIS);
    end

    assign chain = {sync_sr, hsync_raw, vsync_raw, active_raw};

    // RGB is gated by the stage about to become vga_blank_n, so both land on the same edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_sr   <= {PIPE_DELAY{3'b110}};
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else if (pixel_enable) begin
            sync_sr <= chain[3*PIPE_DELAY-1:0];
            if (chain[3*PIPE_DELAY-3]) begin
                vga_red   <= pix.pixel_red;
                vga_green <= pix.pixel_green;
                vga_blue  <= pix.pixel_blue;
            end else begin
                vga_red   <= '0;
                vga_green <= '0;
                vga_blue  <= '0;
            end
        end
    end

    assign vga_hsync       = chain[3*PIPE_DELAY+2];
    assign vga_vsync       = chain[3*PIPE_DELAY+1];
    assign vga_blank_n     = chain[3*PIPE_DELAY];
    assign pix.pixel_x_pos = h_count;
    assign pix.pixel_y_pos = v_count;
    assign pix.active_area = active_raw;
    assign pix.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Drives a shrunken-raster instance and a full 640x480 instance in lockstep and compares
// every output each clock against a tick-count based raster model.
module tb_vga_timing_generator;

    localparam int S_HV = 40, S_HF = 4, S_HS = 6, S_HB = 5;
    localparam int S_VV = 20, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_PD = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

    localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VV = 480, D_VF = 10, D_VS = 2, D_VB = 33;
    localparam int D_PD = 2;
    localparam int D_HT = 800;
    localparam int D_VT = 525;

    logic       clock;
    logic       reset_n;
    logic       pixel_enable;
    logic       s_hsync, s_vsync, s_blank_n;
    logic [7:0] s_red, s_green, s_blue;
    logic       d_hsync, d_vsync, d_blank_n;
    logic [7:0] d_red, d_green, d_blue;

    int          vectors;
    int          miscompares;
    int          ticks;
    logic        fs_s, fs_d;
    logic [23:0] rgb_s, rgb_d;

    vga_timing_generator_if pix_s ();
    vga_timing_generator_if pix_d ();

    vga_timing_generator #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .PIPE_DELAY(S_PD)
    ) dut_small (
        .clock(clock), .reset_n(reset_n), .pixel_enable(pixel_enable), .pix(pix_s),
        .vga_hsync(s_hsync), .vga_vsync(s_vsync), .vga_blank_n(s_blank_n),
        .vga_red(s_red), .vga_green(s_green), .vga_blue(s_blue)
    );

    vga_timing_generator dut_full (
        .clock(clock), .reset_n(reset_n), .pixel_enable(pixel_enable), .pix(pix_d),
        .vga_hsync(d_hsync), .vga_vsync(d_vsync), .vga_blank_n(d_blank_n),
        .vga_red(d_red), .vga_green(d_green), .vga_blue(d_blue)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {hsync, vsync, blank_n} after t ticks since reset, for a raster delayed by pd ticks.
    function automatic logic [2:0] expSync(input int t, input int pd, input int hv, input int hf,
                                           input int hs, input int hb, input int vv, input int vf,
                                           input int vs, input int vb);
        int n, x, y, ht, vt;
        if (t < pd) return 3'b110;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        n  = t - pd;
        x  = n % ht;
        y  = (n / ht) % vt;
        return {!(x >= hv + hf && x < hv + hf + hs), !(y >= vv + vf && y < vv + vf + vs),
                (x < hv && y < vv)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic checkAll();
        int xs, ys, xd, yd;
        logic [2:0] ss, sd;
        xs = ticks % S_HT;
        ys = (ticks / S_HT) % S_VT;
        xd = ticks % D_HT;
        yd = (ticks / D_HT) % D_VT;
        ss = expSync(ticks, S_PD, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
        sd = expSync(ticks, D_PD, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB);
        checkOutput("s_x", 32'(pix_s.pixel_x_pos), 32'(xs));
        checkOutput("s_y", 32'(pix_s.pixel_y_pos), 32'(ys));
        checkOutput("s_active", 32'(pix_s.active_area), 32'(xs < S_HV && ys < S_VV));
        checkOutput("s_frame_start", 32'(pix_s.frame_start), 32'(fs_s));
        checkOutput("s_hsync", 32'(s_hsync), 32'(ss[2]));
        checkOutput("s_vsync", 32'(s_vsync), 32'(ss[1]));
        checkOutput("s_blank_n", 32'(s_blank_n), 32'(ss[0]));
        checkOutput("s_rgb", 32'({s_red, s_green, s_blue}), 32'(rgb_s));
        checkOutput("d_x", 32'(pix_d.pixel_x_pos), 32'(xd));
        checkOutput("d_y", 32'(pix_d.pixel_y_pos), 32'(yd));
        checkOutput("d_active", 32'(pix_d.active_area), 32'(xd < D_HV && yd < D_VV));
        checkOutput("d_frame_start", 32'(pix_d.frame_start), 32'(fs_d));
        checkOutput("d_hsync", 32'(d_hsync), 32'(sd[2]));
        checkOutput("d_vsync", 32'(d_vsync), 32'(sd[1]));
        checkOutput("d_blank_n", 32'(d_blank_n), 32'(sd[0]));
        checkOutput("d_rgb", 32'({d_red, d_green, d_blue}), 32'(rgb_d));
    endtask

    // Drive one clock's inputs, advance the model to what the coming edge should do, check after it.
    task automatic applyStimulus(input logic rst_n_v, input logic en, input logic [7:0] r,
                                 input logic [7:0] g, input logic [7:0] b);
        logic [2:0] ss, sd;
        reset_n             = rst_n_v;
        pixel_enable        = en;
        pix_s.pixel_red     = r;
        pix_s.pixel_green   = g;
        pix_s.pixel_blue    = b;
        pix_d.pixel_red     = r;
        pix_d.pixel_green   = g;
        pix_d.pixel_blue    = b;
        if (!rst_n_v) begin
            ticks = 0;
            fs_s  = 1'b0;
            fs_d  = 1'b0;
            rgb_s = '0;
            rgb_d = '0;
        end else if (en) begin
            ticks++;
            fs_s  = (ticks % (S_HT * S_VT)) == 0;
            fs_d  = (ticks % (D_HT * D_VT)) == 0;
            ss    = expSync(ticks, S_PD, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
            sd    = expSync(ticks, D_PD, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB);
            rgb_s = ss[0] ? {r, g, b} : 24'h0;
            rgb_d = sd[0] ? {r, g, b} : 24'h0;
        end else begin
            fs_s = 1'b0;
            fs_d = 1'b0;
        end
        @(negedge clock);
        checkAll();
    endtask

    initial begin
        int guard;
        vectors     = 0;
        miscompares = 0;
        ticks       = 0;
        fs_s        = 1'b0;
        fs_d        = 1'b0;
        rgb_s       = '0;
        rgb_d       = '0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        $display("[TB] constant colour, tick every second clock");
        for (int i = 0; i < 3400; i++) applyStimulus(1'b1, (i % 2) == 0, 8'hFF, 8'h80, 8'h01);

        $display("[TB] random ticks and colours");
        for (int i = 0; i < 4000; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));

        $display("[TB] freeze mid-line at x=300");
        guard = 0;
        while (pix_d.pixel_x_pos != 10'd300 && guard < 1000) begin
            applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            guard++;
        end
        checkOutput("reach_x300", 32'(pix_d.pixel_x_pos), 32'd300);
        for (int i = 0; i < 50; i++)
            applyStimulus(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        applyStimulus(1'b1, 1'b1, 8'h12, 8'h34, 8'h56);

        $display("[TB] reset inside the vsync line and hsync pulse");
        guard = 0;
        while (!(pix_s.pixel_x_pos == 10'(S_HV + S_HF + 2) && pix_s.pixel_y_pos == 10'(S_VV + S_VF + 1))
               && guard < 3000) begin
            applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            guard++;
        end
        checkOutput("reach_sync_pos", 32'({pix_s.pixel_y_pos, pix_s.pixel_x_pos}),
                    32'({10'(S_VV + S_VF + 1), 10'(S_HV + S_HF + 2)}));
        applyStimulus(1'b0, 1'b1, 8'hAA, 8'hBB, 8'hCC);

        for (int i = 0; i < 1600; i++)
            applyStimulus(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Generates 640x480@60 Hz VGA raster timing.
- Drives pixel_x_pos/pixel_y_pos into video_compositor and the frame-buffer read address logic.
- Takes the compositor's RGB back, registers it, and emits it to the DAC with hsync/vsync/blank delayed to match the fetch+compose pipeline latency.
- Directly upstream and downstream of video_compositor.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
PIPE_DELAY, 2, pixel ticks from position output to valid compositor RGB (1..7)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous reset, active low
pixel_enable  in  1  one-cycle pixel tick (25 MHz rate); all state advances only on ticks
pixel_red  in  8  compositor red
pixel_green  in  8  compositor green
pixel_blue  in  8  compositor blue
pixel_x_pos  out  10  current horizontal count (0..H_TOTAL-1)
pixel_y_pos  out  10  current vertical count (0..V_TOTAL-1)
active_area  out  1  undelayed: x<H_VISIBLE and y<V_VISIBLE
frame_start  out  1  one-clock pulse on tick where counters wrap to (0,0)
vga_hsync  out  1  delayed hsync, active low
vga_vsync  out  1  delayed vsync, active low
vga_blank_n  out  1  delayed active_area
vga_red  out  8  registered output red
vga_green  out  8  registered output green
vga_blue  out  8  registered output blue

Behaviour:
- Reset is synchronous and active low, applied on clock rising edge.
- Interface: single clock `clock`; synchronous active-low reset `reset_n`.
- Derived constants: H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK=800; V_TOTAL=525.
- Reset values: h/v counters 0; pixel_x_pos=0, pixel_y_pos=0; frame_start=0; vga_hsync=1, vga_vsync=1, vga_blank_n=0; vga_rgb=0.
- Reset fills every delay-pipeline stage with inactive values (hsync=1, vsync=1, blank_n=0).
- Counters, on each pixel_enable:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count wraps to 0 when it is V_TOTAL-1 and h wraps.
- No state changes when pixel_enable=0; all outputs hold.
- pixel_x_pos/pixel_y_pos are the registered counters themselves (0 latency relative to counter state).
- active_area is combinational from the counters.
- Raw sync decode:
  - hsync_raw=0 iff H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync_raw=0 iff V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for the whole line.
- Delay pipeline:
  - {hsync_raw, vsync_raw, active_area} pass through a PIPE_DELAY-deep shift register, shifting only on pixel_enable.
  - The last stage drives vga_hsync/vga_vsync/vga_blank_n.
- RGB output:
  - On pixel_enable, vga_rgb <= (blank stage feeding vga_blank_n is active) ? pixel_rgb : 0.
  - vga_rgb and vga_blank_n update on the same clock, so the DAC sees zero RGB outside the visible area.
- frame_start:
  - 1 for exactly one clock, on the clock edge where a tick moves the counters from (799,524) to (0,0).
  - 0 otherwise, including out of reset.
- Reset mid-frame: counters return to (0,0) next edge, pipeline flushes to inactive, no frame_start pulse generated by reset itself.
- Widths: counters 10 bits; parameter sums must stay < 1024 (checked by a generate-time error).

Test Plan:
- Reset released, pixel_enable every 2nd clock, 800 ticks -> pixel_x_pos runs 0..799 then 0; pixel_y_pos goes 0->1 on tick 800.
- Count ticks from reset with PIPE_DELAY=2 -> vga_hsync low for exactly 96 ticks, first low at tick 658, high again at tick 754; period 800 ticks.
- Full frame -> vga_vsync low during lines 490-491 (1600 ticks, plus delay 2); frame_start pulses once per 420000 ticks, each pulse 1 clock wide.
- Drive pixel_rgb=0xFF/0x80/0x01 constant -> vga_rgb equals it only while vga_blank_n=1 (640 ticks/line, lines 0..479), 0 elsewhere; first nonzero two ticks after (0,0).
- Hold pixel_enable=0 for 50 clocks mid-line at x=300 -> all outputs frozen, x=300 resumes to 301 on next tick.
- Assert reset_n=0 for one clock at (700,491) -> next edge counters (0,0), vga_hsync=1, vga_vsync=1, vga_blank_n=0, vga_rgb=0, no frame_start.
